// File: rtl/mem_arbiter.sv
// Round-robin share of one memory port among imap/wt readers and omap writer.
// Latency: grant->arb2mem 1 cycle, rvld->BIU data 1 cycle; held request stalls all grants.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_OUTS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] imap_biu2arb_addr,
  input  logic          imap_biu2arb_vld,
  output logic          imap_biu2arb_rdy,
  output logic [DW-1:0] arb2imap_biu_data,
  output logic          arb2imap_biu_vld,
  input  logic [AW-1:0] wt_biu2arb_addr,
  input  logic          wt_biu2arb_vld,
  output logic          wt_biu2arb_rdy,
  output logic [DW-1:0] arb2wt_biu_data,
  output logic          arb2wt_biu_vld,
  input  logic [AW-1:0] omap_biu2arb_addr,
  input  logic [DW-1:0] omap_biu2arb_data,
  input  logic          omap_biu2arb_vld,
  output logic          omap_biu2arb_rdy,
  output logic [AW-1:0] arb2mem_addr,
  output logic [DW-1:0] arb2mem_wdata,
  output logic          arb2mem_we,
  output logic          arb2mem_vld,
  input  logic          arb2mem_rdy,
  input  logic [DW-1:0] mem2arb_rdata,
  input  logic          mem2arb_rvld,
  output logic          arb_err
);

  localparam int CW = $clog2(MAX_OUTS) + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } mem_req_t;

  typedef enum logic [1:0] {
    REQ_IMAP = 2'd0,
    REQ_WT   = 2'd1,
    REQ_OMAP = 2'd2
  } req_e;

  mem_req_t      req_q, req_d;
  logic          mem_vld_q, mem_vld_d;
  req_e          prio_q, prio_d;
  logic          slot_free;
  logic          rd_ok;
  logic [2:0]    elig;
  logic [2:0]    gnt;
  logic          id_push, id_pop;
  logic [0:0]    id_head;
  logic [CW-1:0] id_cnt;
  logic          id_empty;

  logic          imap_vld_q, wt_vld_q, err_q;
  logic [DW-1:0] imap_dat_q, wt_dat_q;

  assign slot_free = !mem_vld_q | arb2mem_rdy;
  assign id_empty  = (id_cnt == '0);
  assign id_pop    = mem2arb_rvld & !id_empty;
  // A return arriving this cycle frees a slot for a read granted this cycle.
  assign rd_ok     = (id_cnt != CW'(MAX_OUTS)) | id_pop;
  assign elig      = {omap_biu2arb_vld, wt_biu2arb_vld & rd_ok, imap_biu2arb_vld & rd_ok};

  always_comb begin
    gnt = 3'b000;
    if (slot_free) begin
      case (prio_q)
        REQ_IMAP: begin
          if (elig[0])      gnt = 3'b001;
          else if (elig[1]) gnt = 3'b010;
          else if (elig[2]) gnt = 3'b100;
        end
        REQ_WT: begin
          if (elig[1])      gnt = 3'b010;
          else if (elig[2]) gnt = 3'b100;
          else if (elig[0]) gnt = 3'b001;
        end
        default: begin
          if (elig[2])      gnt = 3'b100;
          else if (elig[0]) gnt = 3'b001;
          else if (elig[1]) gnt = 3'b010;
        end
      endcase
    end
  end

  assign imap_biu2arb_rdy = gnt[0];
  assign wt_biu2arb_rdy   = gnt[1];
  assign omap_biu2arb_rdy = gnt[2];

  always_comb begin
    req_d     = req_q;
    mem_vld_d = mem_vld_q;
    prio_d    = prio_q;
    if (slot_free) begin
      mem_vld_d = |gnt;
      if (gnt[0]) begin
        req_d  = '{addr: imap_biu2arb_addr, wdata: '0, we: 1'b0};
        prio_d = REQ_WT;
      end else if (gnt[1]) begin
        req_d  = '{addr: wt_biu2arb_addr, wdata: '0, we: 1'b0};
        prio_d = REQ_OMAP;
      end else if (gnt[2]) begin
        req_d  = '{addr: omap_biu2arb_addr, wdata: omap_biu2arb_data, we: 1'b1};
        prio_d = REQ_IMAP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '0;
      mem_vld_q <= 1'b0;
      prio_q    <= REQ_IMAP;
    end else begin
      req_q     <= req_d;
      mem_vld_q <= mem_vld_d;
      prio_q    <= prio_d;
    end
  end

  assign arb2mem_addr  = req_q.addr;
  assign arb2mem_wdata = req_q.wdata;
  assign arb2mem_we    = req_q.we;
  assign arb2mem_vld   = mem_vld_q;

  // Outstanding-read IDs: 0 = imap, 1 = wt.
  assign id_push = gnt[0] | gnt[1];

  mem_arb_fifo #(
    .W     (1),
    .DEPTH (MAX_OUTS)
  ) u_id_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (id_push),
    .push_dat_i (gnt[1]),
    .pop_i      (id_pop),
    .head_dat_o (id_head),
    .count_o    (id_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imap_vld_q <= 1'b0;
      wt_vld_q   <= 1'b0;
      imap_dat_q <= '0;
      wt_dat_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      imap_vld_q <= id_pop & !id_head[0];
      wt_vld_q   <= id_pop & id_head[0];
      if (id_pop && !id_head[0]) imap_dat_q <= mem2arb_rdata;
      if (id_pop && id_head[0])  wt_dat_q   <= mem2arb_rdata;
      if (mem2arb_rvld && id_empty) err_q <= 1'b1;
    end
  end

  assign arb2imap_biu_vld  = imap_vld_q;
  assign arb2imap_biu_data = imap_dat_q;
  assign arb2wt_biu_vld    = wt_vld_q;
  assign arb2wt_biu_data   = wt_dat_q;
  assign arb_err           = err_q;

endmodule

// Generic synchronous FIFO; head is combinational from storage, count is registered.
// Latency: push visible at head next cycle; no internal backpressure, caller respects count.
module mem_arb_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_dat_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PW'(1);
      if (pop_i)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign count_o    = cnt_q;

endmodule
